// File: rtl/irda_pkg.sv
// Shared IrDA definitions: source indices, selector FSM states,
// and default guard/turnaround timing.
package irda_pkg;

    localparam int IRDA_SRC_SIR = 0;
    localparam int IRDA_SRC_MIR = 1;
    localparam int IRDA_SRC_FIR = 2;

    localparam int IRDA_GUARD_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        SEL_OFF    = 2'd0,
        SEL_ACTIVE = 2'd1,
        SEL_GUARD  = 2'd2
    } irda_sel_state_e;

endpackage

// File: rtl/irda_guard_timer.sv
// Loadable down-counter with zero flag for IrDA guard and
// turnaround timing; saturates at zero.
module irda_guard_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; counting stops at zero.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/irda_tx_out_sel.sv
// Registered IrDA TX pad selector: routes one encoder source to the
// pad, ORs in SIP pulses, applies polarity, guards mode changes.
module irda_tx_out_sel
    import irda_pkg::*;
#(
    parameter int                 NUM_SRC      = 4,
    parameter logic [NUM_SRC-1:0] SIP_MASK     = 4'b0110,
    parameter int                 GUARD_CYCLES = IRDA_GUARD_CYCLES_DEF,
    parameter int                 SELW         = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic [NUM_SRC-1:0] src_tx_i,
    input  logic               sip_i,
    input  logic               tx_select,
    input  logic               tx_invert,
    input  logic [SELW-1:0]    mode_sel_i,
    output logic               tx_pad_o,
    output logic [SELW-1:0]    mode_cur_o,
    output logic               mode_ack_o,
    output logic               switching_o,
    output logic               mode_err_o
);

    localparam int            TW         = 16;
    localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);

    irda_sel_state_e state_q, state_d;
    logic [SELW-1:0] cur_q, cur_d;
    logic [SELW-1:0] target_q, target_d;
    logic            pad_q, pad_d;
    logic            ack_q, ack_d;
    logic            sel_err;
    logic            tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0]   tmr_val;
    logic [TW-1:0]   guard_val;
    logic            drv_cur, drv_tgt;

    // An illegal request parks the guard at zero so it never completes.
    assign sel_err   = 32'(mode_sel_i) >= NUM_SRC;
    assign guard_val = sel_err ? '0 : GUARD_LOAD;

    assign drv_cur = (src_tx_i[cur_q] | (sip_i & SIP_MASK[cur_q])) ^ tx_invert;
    assign drv_tgt = (src_tx_i[target_q] | (sip_i & SIP_MASK[target_q])) ^ tx_invert;

    irda_guard_timer #(
        .W (TW)
    ) u_guard (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_o   (tmr_zero)
    );

    // Next-state and next-pad logic; the pad idles at tx_invert.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        ack_d    = 1'b0;
        pad_d    = tx_invert;
        tmr_load = 1'b0;
        tmr_val  = guard_val;
        tmr_dec  = 1'b0;
        unique case (state_q)
            SEL_OFF: begin
                if (tx_select) begin
                    if ((mode_sel_i == cur_q) && !sel_err) begin
                        state_d = SEL_ACTIVE;
                    end else begin
                        state_d  = SEL_GUARD;
                        target_d = mode_sel_i;
                        tmr_load = 1'b1;
                    end
                end
            end
            SEL_ACTIVE: begin
                if (!tx_select) begin
                    state_d = SEL_OFF;
                end else if (mode_sel_i != cur_q) begin
                    state_d  = SEL_GUARD;
                    target_d = mode_sel_i;
                    tmr_load = 1'b1;
                end else begin
                    pad_d = drv_cur;
                end
            end
            SEL_GUARD: begin
                if (!tx_select) begin
                    state_d = SEL_OFF;
                end else if (mode_sel_i != target_q) begin
                    target_d = mode_sel_i;
                    tmr_load = 1'b1;
                end else if (sel_err) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_d = SEL_ACTIVE;
                    cur_d   = target_q;
                    ack_d   = 1'b1;
                    pad_d   = drv_tgt;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = SEL_OFF;
            end
        endcase
    end

    // State, selection and pad registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= SEL_OFF;
            cur_q    <= '0;
            target_q <= '0;
            pad_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            pad_q    <= pad_d;
            ack_q    <= ack_d;
        end
    end

    assign tx_pad_o    = pad_q;
    assign mode_cur_o  = cur_q;
    assign mode_ack_o  = ack_q;
    assign switching_o = (state_q == SEL_GUARD);
    assign mode_err_o  = sel_err & ~wb_rst_i;

endmodule

// File: tb/tb_irda_tx_out_sel.sv
// Self-checking bench for irda_tx_out_sel: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_irda_tx_out_sel;

    // Five sources so that an illegal select value (5..7) is reachable.
    localparam int             N    = 5;
    localparam int             G    = 16;
    localparam int             SW   = 3;
    localparam logic [N-1:0]   MASK = 5'b00110;

    localparam int P_OFF = 0;
    localparam int P_ACT = 1;
    localparam int P_GRD = 2;

    logic          clk = 1'b0;
    logic          wb_rst_i;
    logic [N-1:0]  src_tx_i;
    logic          sip_i;
    logic          tx_select;
    logic          tx_invert;
    logic [SW-1:0] mode_sel_i;
    logic          tx_pad_o;
    logic [SW-1:0] mode_cur_o;
    logic          mode_ack_o;
    logic          switching_o;
    logic          mode_err_o;
    logic [6:0]    dut_vec;

    int tests_run = 0;
    int fails     = 0;

    int   m_phase;
    int   m_cur;
    int   m_tgt;
    int   m_served;
    logic m_pad;
    logic m_ack;

    always #5 clk = ~clk;

    irda_tx_out_sel #(
        .NUM_SRC      (N),
        .SIP_MASK     (MASK),
        .GUARD_CYCLES (G)
    ) dut (
        .clk         (clk),
        .wb_rst_i    (wb_rst_i),
        .src_tx_i    (src_tx_i),
        .sip_i       (sip_i),
        .tx_select   (tx_select),
        .tx_invert   (tx_invert),
        .mode_sel_i  (mode_sel_i),
        .tx_pad_o    (tx_pad_o),
        .mode_cur_o  (mode_cur_o),
        .mode_ack_o  (mode_ack_o),
        .switching_o (switching_o),
        .mode_err_o  (mode_err_o)
    );

    assign dut_vec = {tx_pad_o, mode_cur_o, mode_ack_o, switching_o, mode_err_o};

    task automatic model_reset();
        m_phase  = P_OFF;
        m_cur    = 0;
        m_tgt    = 0;
        m_served = 0;
        m_pad    = 1'b0;
        m_ack    = 1'b0;
    endtask

    function automatic logic src_val(int idx);
        return (src_tx_i[idx] | (sip_i & MASK[idx])) ^ tx_invert;
    endfunction

    // One clock edge of the reference: "served" counts idle cycles
    // already spent; the new source takes over once G have elapsed.
    task automatic model_step();
        int ms;
        ms    = int'(mode_sel_i);
        m_ack = 1'b0;
        m_pad = tx_invert;
        if (!tx_select) begin
            m_phase = P_OFF;
        end else if (m_phase == P_OFF) begin
            if (ms == m_cur) begin
                m_phase = P_ACT;
            end else begin
                m_phase  = P_GRD;
                m_tgt    = ms;
                m_served = 1;
            end
        end else if (m_phase == P_ACT) begin
            if (ms != m_cur) begin
                m_phase  = P_GRD;
                m_tgt    = ms;
                m_served = 1;
            end else begin
                m_pad = src_val(m_cur);
            end
        end else begin
            if (ms != m_tgt) begin
                m_tgt    = ms;
                m_served = 1;
            end else if (ms >= N) begin
                m_served = m_served;
            end else if (m_served >= G) begin
                m_cur   = m_tgt;
                m_ack   = 1'b1;
                m_phase = P_ACT;
                m_pad   = src_val(m_cur);
            end else begin
                m_served++;
            end
        end
    endtask

    function automatic logic [6:0] exp_vec();
        return {m_pad, 3'(m_cur), m_ack, (m_phase == P_GRD),
                (int'(mode_sel_i) >= N)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int acks;
        acks       = 0;
        wb_rst_i   = 1'b1;
        tx_select  = 1'b1;
        mode_sel_i = 3'd0;
        src_tx_i   = 5'b00001;
        sip_i      = 1'b0;
        tx_invert  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (dut_vec !== 7'b0)
            $display("FAIL reset_vals got=%b want=%b", dut_vec, 7'b0);
        if (dut_vec !== 7'b0) fails++;
        tx_invert = 1'b0;
        wb_rst_i  = 1'b0;
        tick();
        acks += int'(mode_ack_o);
        tests_run++;
        if (tx_pad_o !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_edge1 got=%b want=%b", dut_vec, exp_vec());
        end
        tick();
        acks += int'(mode_ack_o);
        tests_run++;
        if (tx_pad_o !== 1'b1 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_edge2 got=%b want=%b", dut_vec, exp_vec());
        end
        tests_run++;
        if (acks != 0) begin
            fails++;
            $display("FAIL reset_no_ack got=%0d want=0", acks);
        end
    endtask

    task automatic test_switch();
        int idle;
        int acks;
        idle       = 0;
        acks       = 0;
        mode_sel_i = 3'd2;
        for (int i = 0; i < 24; i++) begin
            src_tx_i = 5'($urandom) | 5'b00100;
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL switch_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
            if (switching_o && !tx_pad_o) idle++;
            if (mode_ack_o) acks++;
        end
        tests_run++;
        if (idle != G || acks != 1) begin
            fails++;
            $display("FAIL switch_guard got idle=%0d ack=%0d want idle=%0d ack=1", idle, acks, G);
        end
        tests_run++;
        if (mode_cur_o !== 3'd2 || tx_pad_o !== 1'b1) begin
            fails++;
            $display("FAIL switch_end got cur=%0d pad=%b want cur=2 pad=1", mode_cur_o, tx_pad_o);
        end
    endtask

    task automatic test_sip();
        logic [1:0] seen;
        for (int m = 1; m >= 0; m--) begin
            mode_sel_i = SW'(m);
            for (int i = 0; i < 20; i++) begin
                src_tx_i = 5'($urandom) & ~(5'b00001 << m);
                tick();
                tests_run++;
                if (dut_vec !== exp_vec()) begin
                    fails++;
                    $display("FAIL sip_settle m=%0d got=%b want=%b", m, dut_vec, exp_vec());
                end
            end
            sip_i = 1'b1;
            tick();
            seen[0] = tx_pad_o;
            sip_i   = 1'b0;
            tick();
            seen[1] = tx_pad_o;
            tests_run++;
            if (seen !== ((m == 1) ? 2'b01 : 2'b00)) begin
                fails++;
                $display("FAIL sip_pulse m=%0d got=%b want=%b", m, seen,
                         (m == 1) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_restart();
        int sw;
        int acks;
        sw         = 0;
        acks       = 0;
        src_tx_i   = 5'b00100;
        mode_sel_i = 3'd1;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) mode_sel_i = 3'd2;
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL restart_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
            if (switching_o) sw++;
            if (mode_ack_o) acks++;
        end
        tests_run++;
        if (sw != 5 + G || acks != 1 || mode_cur_o !== 3'd2) begin
            fails++;
            $display("FAIL restart_guard got sw=%0d ack=%0d cur=%0d want sw=%0d ack=1 cur=2",
                     sw, acks, mode_cur_o, 5 + G);
        end
    endtask

    task automatic test_err();
        int bad;
        int sw;
        int acks;
        bad        = 0;
        sw         = 0;
        acks       = 0;
        mode_sel_i = 3'd7;
        for (int i = 0; i < 40; i++) begin
            src_tx_i = 5'($urandom);
            tick();
            if (!mode_err_o || tx_pad_o || mode_ack_o || mode_cur_o !== 3'd2) bad++;
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL err_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL err_hold got bad_cycles=%0d want 0", bad);
        end
        mode_sel_i = 3'd3;
        for (int i = 0; i < 24; i++) begin
            src_tx_i = 5'($urandom) | 5'b01000;
            tick();
            if (switching_o) sw++;
            if (mode_ack_o) acks++;
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL err_recover cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
        tests_run++;
        if (sw != G || acks != 1 || mode_cur_o !== 3'd3 || mode_err_o !== 1'b0) begin
            fails++;
            $display("FAIL err_guard got sw=%0d ack=%0d cur=%0d err=%b want sw=%0d ack=1 cur=3 err=0",
                     sw, acks, mode_cur_o, mode_err_o, G);
        end
    endtask

    task automatic test_invert();
        tx_select = 1'b0;
        tx_invert = 1'b1;
        tick();
        tests_run++;
        if (tx_pad_o !== 1'b1 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL inv_off got=%b want=%b", dut_vec, exp_vec());
        end
        tx_select  = 1'b1;
        mode_sel_i = 3'd1;
        src_tx_i   = 5'b00010;
        repeat (20) tick();
        tests_run++;
        if (tx_pad_o !== 1'b0 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL inv_active got=%b want=%b", dut_vec, exp_vec());
        end
        mode_sel_i = 3'd2;
        repeat (4) tick();
        tests_run++;
        if (tx_pad_o !== 1'b1 || switching_o !== 1'b1) begin
            fails++;
            $display("FAIL inv_guard got pad=%b sw=%b want pad=1 sw=1", tx_pad_o, switching_o);
        end
        #2;
        wb_rst_i = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (tx_pad_o !== 1'b0 || switching_o !== 1'b0 || mode_ack_o !== 1'b0) begin
            fails++;
            $display("FAIL inv_reset got pad=%b sw=%b ack=%b want 0 0 0",
                     tx_pad_o, switching_o, mode_ack_o);
        end
        @(posedge clk);
        #1;
        wb_rst_i  = 1'b0;
        tx_invert = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            src_tx_i  = 5'($urandom);
            sip_i     = ($urandom_range(0, 3) == 0);
            tx_select = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 15) == 0) tx_invert = ~tx_invert;
            if ($urandom_range(0, 30) == 0) mode_sel_i = SW'($urandom_range(0, 7));
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_sip();
        test_restart();
        test_err();
        test_invert();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
